// File: rtl/decay_pkg.sv
// Shared decay-mode encodings and sweep FSM states for the potential decay engine.
package decay_pkg;

  localparam logic [2:0] DECAY_HOLD = 3'b000;
  localparam logic [2:0] DECAY_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

endpackage

// File: rtl/decay_calc.sv
// Combinational shift-based leak f(V, m); optional snap-to-zero when DECAY_SNAP_EN is defined.
module decay_calc
  import decay_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SNAP_THRESH = 4
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic        [2:0]       m,
  output logic signed [WIDTH-1:0] r
);

`ifdef DECAY_SNAP_EN
  localparam logic signed [WIDTH-1:0] THRESH = WIDTH'(SNAP_THRESH);
`endif

  logic signed [WIDTH-1:0] shifted;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    shifted = v >>> m;
    r       = v;
    case (m)
      DECAY_HOLD: r = v;
      DECAY_ZERO: r = '0;
      default: begin
        // Arithmetic shift floors toward -inf, so subtracting it moves V toward 0.
        r = v - shifted;
`ifdef DECAY_SNAP_EN
        if ((r < THRESH) && (r > -THRESH)) r = '0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/potential_decay_array.sv
// Time-multiplexed membrane-potential decay engine: one neuron per cycle per time_step sweep.
// Optional snap-to-zero of small results is enabled by defining DECAY_SNAP_EN.
module potential_decay_array
  import decay_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = $clog2(NUM_NEURONS),
  parameter int SNAP_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     time_step,
  input  logic                     load,
  input  logic        [ADDR_W-1:0] load_addr,
  input  logic signed [WIDTH-1:0]  load_potential,
  input  logic        [2:0]        load_mode,
  input  logic        [ADDR_W-1:0] rd_addr,
  output logic signed [WIDTH-1:0]  rd_potential,
  output logic                     busy,
  output logic                     done,
  output logic                     step_overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  logic signed [WIDTH-1:0] pot  [NUM_NEURONS];
  logic        [2:0]       mode [NUM_NEURONS];
  state_t                  state;
  logic        [ADDR_W-1:0] idx;
  logic signed [WIDTH-1:0] decayed;

  decay_calc #(
    .WIDTH       (WIDTH),
    .SNAP_THRESH (SNAP_THRESH)
  ) u_calc (
    .v (pot[idx]),
    .m (mode[idx]),
    .r (decayed)
  );

  // NOTE: the potential array lives in flops and must read 0 after reset, so it is
  // cleared here rather than left to power-up contents as a RAM would be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot[i]  <= '0;
        mode[i] <= DECAY_HOLD;
      end
      state        <= IDLE;
      idx          <= '0;
      rd_potential <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_overrun <= 1'b0;
    end else begin
      rd_potential <= pot[rd_addr];
      done         <= 1'b0;
      step_overrun <= time_step && (state != IDLE);

      case (state)
        IDLE: begin
          if (time_step) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          pot[idx] <= decayed;
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase

      // NOTE: non-blocking updates let the later load override the sweep write to the
      // same entry on this edge, while reads above still see the pre-edge contents.
      if (load) begin
        pot[load_addr]  <= load_potential;
        mode[load_addr] <= load_mode;
      end
    end
  end

endmodule

// File: tb/tb_potential_decay_array.sv
// Randomised and directed bench for potential_decay_array against an event-level reference model.
module tb_potential_decay_array;

  localparam int WIDTH  = 32;
  localparam int N      = 16;
  localparam int ADDR_W = $clog2(N);
  localparam int SNAP   = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     time_step;
  logic                     load;
  logic        [ADDR_W-1:0] load_addr;
  logic signed [WIDTH-1:0]  load_potential;
  logic        [2:0]        load_mode;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [WIDTH-1:0]  rd_potential;
  logic                     busy;
  logic                     done;
  logic                     step_overrun;

  int checks = 0;
  int errors = 0;
  int ovr_seen;

  // Reference state: potentials, modes, and position within a sweep (edges since the accepting edge).
  longint m_pot  [N];
  int     m_mode [N];
  bit     m_active;
  int     m_pos;

  potential_decay_array #(
    .WIDTH       (WIDTH),
    .NUM_NEURONS (N),
    .ADDR_W      (ADDR_W),
    .SNAP_THRESH (SNAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .time_step      (time_step),
    .load           (load),
    .load_addr      (load_addr),
    .load_potential (load_potential),
    .load_mode      (load_mode),
    .rd_addr        (rd_addr),
    .rd_potential   (rd_potential),
    .busy           (busy),
    .done           (done),
    .step_overrun   (step_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // V - floor(V / 2^m), with hold and full-leak modes, plus optional snap.
  function automatic longint f_ref(input longint v, input int m);
    longint d, q, r;
    if (m == 0) return v;
    if (m == 7) return 0;
    d = longint'(1) << m;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    r = v - q;
`ifdef DECAY_SNAP_EN
    if (r > -SNAP && r < SNAP) r = 0;
`endif
    return r;
  endfunction

  task automatic tick();
    longint n_rd;
    bit     n_over;
    n_rd   = m_pot[rd_addr];
    n_over = time_step && m_active;
    if (rst) begin
      foreach (m_pot[i]) begin
        m_pot[i]  = 0;
        m_mode[i] = 0;
      end
      m_active = 0;
      m_pos    = 0;
      n_rd     = 0;
      n_over   = 0;
    end else begin
      if (m_active) begin
        m_pos++;
        if (m_pos <= N) m_pot[m_pos-1] = f_ref(m_pot[m_pos-1], m_mode[m_pos-1]);
        if (m_pos == N + 1) m_active = 0;
      end else if (time_step) begin
        m_active = 1;
        m_pos    = 0;
      end
      if (load) begin
        m_pot[load_addr]  = longint'(load_potential);
        m_mode[load_addr] = int'(load_mode);
      end
    end
    @(posedge clk);
    #1;
    check("busy", busy, longint'(m_active));
    check("done", done, longint'(m_active && m_pos == N));
    check("overrun", step_overrun, longint'(n_over));
    check("rd", rd_potential, n_rd);
    if (step_overrun) ovr_seen++;
  endtask

  task automatic set_load(input int addr, input longint val, input int m);
    load           = 1'b1;
    load_addr      = ADDR_W'(addr);
    load_potential = WIDTH'(val);
    load_mode      = 3'(m);
  endtask

  task automatic read_exp(input int addr, input longint exp, input string tag);
    rd_addr = ADDR_W'(addr);
    tick();
    check(tag, rd_potential, exp);
  endtask

  // Pulse time_step for one cycle and wait (bounded) for done; latency counts the step cycle.
  task automatic sweep_wait();
    int cnt;
    cnt       = 0;
    time_step = 1'b1;
    do begin
      tick();
      time_step = 1'b0;
      cnt++;
    end while (!done && cnt < 100);
    check("done_latency", cnt, N + 1);
    tick();
  endtask

  initial begin
    int cnt;
    rst = 1'b1; time_step = 1'b0; load = 1'b0;
    load_addr = '0; load_potential = '0; load_mode = '0; rd_addr = '0;
    m_active = 0; m_pos = 0;
    foreach (m_pot[i]) begin m_pot[i] = 0; m_mode[i] = 0; end
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) read_exp(i, 0, "reset_rd");

    // Mode coverage and two successive sweeps of a mode-001 neuron.
    set_load(3, 1000, 1); tick();
    set_load(0, 1000, 2); tick();
    set_load(1, -1000, 1); tick();
    set_load(2, 1234, 0); tick();
    set_load(5, 777, 7); tick();
    load = 1'b0;
    sweep_wait();
    read_exp(3, 500, "n3_sweep1");
    read_exp(0, 750, "n0_mode2");
    read_exp(1, -500, "n1_neg");
    read_exp(2, 1234, "n2_hold");
    read_exp(5, 0, "n5_zero");
    sweep_wait();
    read_exp(3, 250, "n3_sweep2");

    // Re-asserted time_step mid-sweep: one overrun, done timing unchanged.
    ovr_seen  = 0;
    cnt       = 0;
    time_step = 1'b1;
    do begin
      tick();
      cnt++;
      time_step = (cnt == 4);
    end while (!done && cnt < 100);
    time_step = 1'b0;
    check("ovr_done_latency", cnt, N + 1);
    tick();
    tick();
    check("ovr_pulses", ovr_seen, 1);
    read_exp(3, 125, "n3_once");

    // Load collision with sweep index k, and early load of the last neuron.
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
    set_load(N - 1, 100, 1);
    tick();
    load = 1'b0;
    repeat (6) tick();
    set_load(7, 100, 1);
    tick();
    load = 1'b0;
    repeat (N) tick();
    read_exp(7, 100, "collide_load_wins");
    read_exp(N - 1, 50, "early_load_decayed");

    // Small-magnitude result: snapped to 0 only with DECAY_SNAP_EN.
    set_load(4, 6, 1); tick();
    load = 1'b0;
    sweep_wait();
`ifdef DECAY_SNAP_EN
    read_exp(4, 0, "snap");
`else
    read_exp(4, 3, "no_snap");
`endif

    // Reset mid-sweep aborts everything; a following sweep runs cleanly.
    time_step = 1'b1; tick(); time_step = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", busy, 0);
    for (int i = 0; i < N; i++) read_exp(i, 0, "rst_rd");
    sweep_wait();

    // Randomised traffic, all outputs compared against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      time_step = ($urandom_range(0, 11) == 0);
      load      = ($urandom_range(0, 3) == 0);
      load_addr = ADDR_W'($urandom_range(0, N - 1));
      load_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) load_potential = WIDTH'($urandom);
      else load_potential = WIDTH'(int'($urandom_range(0, 60)) - 30);
      rd_addr = ADDR_W'($urandom_range(0, N - 1));
      tick();
    end
    rst = 1'b0; load = 1'b0; time_step = 1'b0;
    repeat (N + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/potential_decay_array.md
# potential_decay_array

Time-multiplexed membrane-potential decay engine for a population of NUM_NEURONS neurons. It holds every neuron's signed potential and a per-neuron decay mode. On each `time_step` pulse it sweeps all neurons, one per cycle, and applies the selected shift-based leak. It sits between the synaptic accumulation stage, which loads potentials, and the spike/threshold stage, which reads them. It is the multi-neuron, per-neuron-mode successor of the single-register `potential_decay` block.

## Interface
- `WIDTH`, 32, potential width, signed two's complement
- `NUM_NEURONS`, 16, number of neurons; ≥2
- `ADDR_W`, $clog2(NUM_NEURONS), neuron address width
- `SNAP_THRESH`, 4, snap-to-zero magnitude; used only with DECAY_SNAP_EN
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `time_step`  in  1  starts one decay sweep; sampled on the rising edge of `clk`
- `load`  in  1  write potential and mode for `load_addr`
- `load_addr`  in  ADDR_W  neuron index for the load
- `load_potential`  in  WIDTH  new potential value
- `load_mode`  in  3  new decay mode for the neuron
- `rd_addr`  in  ADDR_W  read address
- `rd_potential`  out  WIDTH  registered read data
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse after the last neuron is written
- `step_overrun`  out  1  one-cycle pulse when `time_step` arrives while busy

## Operation
- Storage: `pot[NUM_NEURONS]` (WIDTH bits each) and `mode[NUM_NEURONS]` (3 bits each), held in flops.
- Decay function f(V, m):
  - m=000: hold, V is unchanged.
  - m=001..110: V − (V >>> m), using an arithmetic shift. Result moves toward 0 and never changes sign. −1 maps to 0.
  - m=111: V becomes 0 (full leak).
- FSM has three states:
  - IDLE → SWEEP on `time_step`. The index counter `idx` is cleared to 0.
  - SWEEP: each cycle writes `pot[idx]` ← f(`pot[idx]`, `mode[idx]`), then increments `idx`. After `idx`=NUM_NEURONS−1 is written, the FSM goes to DONE.
  - DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `busy` = 1 in SWEEP and in DONE.
- `time_step` while `busy`=1:
  - It is ignored. The sweep is neither restarted nor extended.
  - `step_overrun` pulses for one cycle.
- `time_step` in the DONE cycle also counts as an overrun.
- Load behaviour:
  - `load` is accepted in any state.
  - It writes both `pot[load_addr]` and `mode[load_addr]`.
  - If `load_addr` equals the sweep write index in the same cycle, the load wins and the decayed value is discarded.
  - If a neuron is loaded before the sweep reaches it, the loaded value is decayed in this sweep.
- Reads use read-before-write semantics. `rd_potential` returns the array contents as they were before any write on the same edge.

## Timing
- Reset values:
  - All `pot` entries = 0 and all `mode` entries = 000.
  - `rd_potential` = 0, `busy` = 0, `done` = 0, `step_overrun` = 0.
  - State = IDLE and `idx` = 0.
- Reset mid-sweep: the sweep aborts and all of the reset values above apply on the next edge.
- `time_step` sampled high at edge t0 in IDLE:
  - `busy` rises after t0.
  - Neuron i is updated at edge t0+1+i.
  - `done` is high in the cycle after edge t0+NUM_NEURONS.
  - `busy` falls after edge t0+NUM_NEURONS+1.
- Sweep length is NUM_NEURONS+1 cycles. A new `time_step` is accepted from the IDLE cycle that follows.
- Load latency: the value is visible on `rd_potential` two edges after `load` is sampled (write edge, then read edge).
- `rd_potential` latency is one cycle from `rd_addr`.
- `time_step` is level-sampled. A multi-cycle pulse starts one sweep; the cycles where it is still high while `busy` produce overrun pulses.

## Configuration
- `DECAY_SNAP_EN` defined:
  - After f(), any result with |V| < SNAP_THRESH is written as 0. This applies to modes 001..110 only; hold mode (000) is never snapped.
  - This stops residual leak from lingering at small magnitudes.
- `DECAY_SNAP_EN` undefined:
  - f() results are written unmodified.
  - SNAP_THRESH is unused.

## Structure
- Package `decay_pkg`: mode localparams `DECAY_HOLD`=3'b000 and `DECAY_ZERO`=3'b111, and the FSM state enum (IDLE, SWEEP, DONE).
- Sub-module `decay_calc`: combinational f(V, m) plus the optional snap logic, parametrised by WIDTH. The top level owns the storage, FSM, index counter and read port.

## Test plan
- Load neuron 3 with 1000, mode 001; pulse `time_step` twice → `rd_potential` for neuron 3 reads 500, then 250. `done` pulses once per sweep, NUM_NEURONS+1 cycles after each step.
- Decay results across modes after one sweep:
  - Neuron 0: 1000, mode 010 → 750.
  - Neuron 1: −1000, mode 001 → −500.
  - Neuron 2: 1234, mode 000 → 1234.
  - Neuron 5: 777, mode 111 → 0.
- Re-assert `time_step` 3 cycles into a sweep → `step_overrun` pulses once; `done` is still at the original cycle; each neuron is decayed exactly once.
- During a sweep, load neuron k with 100 (mode 001) in the same cycle that `idx`=k → neuron k reads 100 after the sweep. Load neuron NUM_NEURONS−1 with 100 before the sweep reaches it → it reads 50.
- Assert `rst` mid-sweep → next cycle `busy`=0, every `rd_potential` read returns 0, and a following `time_step` starts a clean sweep.
- With DECAY_SNAP_EN and SNAP_THRESH=4: neuron at 6, mode 001 → 3 snaps to 0. Without the macro → 3.
